// File: rtl/display_arbiter.sv
// Round-robin owner arbitration of the shared 4-digit display
// with a minimum hold time before a waiting requester can preempt.
module display_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int HOLD_CYCLES = 1000,
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [15:0]            disp_val,
  output logic                   disp_blank,
  output logic [2:0]             owner_id
);

  typedef enum logic {
    S_IDLE,
    S_OWNED
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]       LAST    = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);

  state_t             r_state, w_state_d;
  logic [NUM_REQ-1:0] r_grant, w_grant_d;
  logic [15:0]        r_val, w_val_d;
  logic               r_blank, w_blank_d;
  logic [2:0]         r_owner, w_owner_d;
  logic [2:0]         r_rr, w_rr_d;
  logic [CNT_W-1:0]   r_hold, w_hold_d;

  logic               w_own_req;
  logic               w_others;
  logic               w_expire;
  logic [2:0]         w_nxt_start;
  logic [2:0]         w_win_rr;
  logic [2:0]         w_win_nx;
  logic [15:0]        w_own_data;
  logic [15:0]        w_rr_data;
  logic [15:0]        w_nx_data;

  // Winner is the set request at the smallest circular distance from s.
  function automatic logic [2:0] f_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [2:0]         s
  );
    int best;
    int d;
    f_pick = 3'd0;
    best   = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - int'(s)) % NUM_REQ;
      if (r[i] && d < best) begin
        best   = d;
        f_pick = 3'(i);
      end
    end
  endfunction

  function automatic logic [15:0] f_sel(
    input logic [16*NUM_REQ-1:0] d,
    input logic [2:0]            idx
  );
    f_sel = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == 3'(i)) f_sel = d[16*i +: 16];
    end
  endfunction

  assign w_own_req   = |(req & r_grant);
  assign w_others    = |(req & ~r_grant);
  assign w_expire    = (r_hold == '0) && w_others;
  assign w_nxt_start = (r_owner == LAST) ? 3'd0 : r_owner + 3'd1;
  assign w_win_rr    = f_pick(req, r_rr);
  assign w_win_nx    = f_pick(req, w_nxt_start);
  assign w_own_data  = f_sel(data, r_owner);
  assign w_rr_data   = f_sel(data, w_win_rr);
  assign w_nx_data   = f_sel(data, w_win_nx);

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_val_d   = r_val;
    w_blank_d = r_blank;
    w_owner_d = r_owner;
    w_rr_d    = r_rr;
    w_hold_d  = r_hold;
    unique case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_d = S_OWNED;
          w_grant_d = ONE << w_win_rr;
          w_owner_d = w_win_rr;
          w_val_d   = w_rr_data;
          w_blank_d = 1'b0;
          w_hold_d  = HOLD_LD;
        end
      end
      S_OWNED: begin
        unique case (1'b1)
          !w_own_req: begin
            w_rr_d = w_nxt_start;
            if (w_others) begin
              w_grant_d = ONE << w_win_nx;
              w_owner_d = w_win_nx;
              w_val_d   = w_nx_data;
              w_hold_d  = HOLD_LD;
            end else begin
              w_state_d = S_IDLE;
              w_grant_d = '0;
              w_owner_d = 3'd0;
              w_blank_d = 1'b1;
            end
          end
          w_own_req && w_expire: begin
            w_rr_d    = w_nxt_start;
            w_grant_d = ONE << w_win_nx;
            w_owner_d = w_win_nx;
            w_val_d   = w_nx_data;
            w_hold_d  = HOLD_LD;
          end
          default: begin
            w_val_d = w_own_data;
            if (r_hold != '0) w_hold_d = r_hold - CNT_W'(1);
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_val   <= 16'h0000;
      r_blank <= 1'b1;
      r_owner <= 3'd0;
      r_rr    <= 3'd0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_val   <= w_val_d;
      r_blank <= w_blank_d;
      r_owner <= w_owner_d;
      r_rr    <= w_rr_d;
      r_hold  <= w_hold_d;
    end
  end

  assign grant      = r_grant;
  assign disp_val   = r_val;
  assign disp_blank = r_blank;
  assign owner_id   = r_owner;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed table, corner sequences,
// and random traffic against an index-based reference model.
module tb_display_arbiter;

  localparam int N = 4;
  localparam int H = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [16*N-1:0] data;
  logic [N-1:0]    grant;
  logic [15:0]     disp_val;
  logic            disp_blank;
  logic [2:0]      owner_id;

  int n_chk  = 0;
  int n_fail = 0;

  display_arbiter #(
    .NUM_REQ     (N),
    .HOLD_CYCLES (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data       (data),
    .grant      (grant),
    .disp_val   (disp_val),
    .disp_blank (disp_blank),
    .owner_id   (owner_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  g;
    logic [15:0] v;
    logic        b;
    logic [2:0]  o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [3:0] r, input logic [63:0] d,
    input logic [3:0] g, input logic [15:0] v,
    input logic b, input logic [2:0] o
  );
    vec_t t;
    t.req = r; t.data = d; t.g = g;
    t.v = v; t.b = b; t.o = o;
    return t;
  endfunction

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string tag, input logic [3:0] g,
                         input logic [15:0] v, input logic b,
                         input logic [2:0] o);
    cmp({tag, ".grant"}, 32'(grant), 32'(g));
    cmp({tag, ".val"},   32'(disp_val), 32'(v));
    cmp({tag, ".blank"}, 32'(disp_blank), 32'(b));
    cmp({tag, ".owner"}, 32'(owner_id), 32'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: owner as an integer (-1 = nobody), plain modulo search.
  int          m_own;
  int          m_hold;
  int          m_rr;
  logic [15:0] m_val;

  function automatic int pick(input int s, input logic [3:0] r);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (s + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] dsel(input logic [63:0] d, input int i);
    return d[16*i +: 16];
  endfunction

  task automatic model_reset();
    m_own = -1; m_hold = 0; m_rr = 0; m_val = 16'h0000;
  endtask

  task automatic grant_to(input int w, input logic [63:0] d);
    m_own = w; m_hold = H - 1; m_val = dsel(d, w);
  endtask

  task automatic model_step(input logic [3:0] r, input logic [63:0] d);
    logic [3:0] others;
    if (m_own < 0) begin
      if (r != 0) grant_to(pick(m_rr, r), d);
    end else begin
      others = r & ~(4'(1) << m_own);
      if (!r[m_own]) begin
        m_rr = (m_own + 1) % N;
        if (r != 0) grant_to(pick(m_rr, r), d);
        else m_own = -1;
      end else if (m_hold == 0 && others != 0) begin
        m_rr = (m_own + 1) % N;
        grant_to(pick(m_rr, r), d);
      end else begin
        m_val = dsel(d, m_own);
        if (m_hold > 0) m_hold--;
      end
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    data  = '0;
    model_reset();

    tbl.push_back(mk(4'b0000, 64'h0, 4'b0000, 16'h0000, 1, 0));
    tbl.push_back(mk(4'b0001, 64'h0000_0000_0000_5555, 4'b0001, 16'h5555, 0, 0));
    tbl.push_back(mk(4'b0001, 64'h0000_0000_0000_1234, 4'b0001, 16'h1234, 0, 0));
    tbl.push_back(mk(4'b0000, 64'h0000_0000_0000_9999, 4'b0000, 16'h1234, 1, 0));
    tbl.push_back(mk(4'b0100, 64'h0000_AAAA_0000_0000, 4'b0100, 16'hAAAA, 0, 2));
    tbl.push_back(mk(4'b1100, 64'h3333_AAAB_0000_0000, 4'b0100, 16'hAAAB, 0, 2));
    tbl.push_back(mk(4'b1000, 64'h3333_AAAB_0000_0000, 4'b1000, 16'h3333, 0, 3));
    tbl.push_back(mk(4'b0000, 64'h3333_AAAB_0000_0000, 4'b0000, 16'h3333, 1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(4'b0011, 64'h0000_0000_1B1B_0A0A, 4'b0001, 16'h0A0A, 0, 0));
    tbl.push_back(mk(4'b0011, 64'h0000_0000_1B1B_0A0A, 4'b0010, 16'h1B1B, 0, 1));

    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      cmp_out("idle", 4'b0000, 16'h0000, 1'b1, 3'd0);
    end

    foreach (tbl[i]) begin
      req  = tbl[i].req;
      data = tbl[i].data;
      tick();
      cmp_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].v,
              tbl[i].b, tbl[i].o);
    end

    // Owner 1 drops, 2 takes over; then reset lands between edges.
    req  = 4'b0100;
    data = 64'h0000_C0DE_0000_0000;
    tick();
    cmp_out("handoff", 4'b0100, 16'hC0DE, 1'b0, 3'd2);
    #2 reset = 1'b0;
    #1 cmp_out("async_rst", 4'b0000, 16'h0000, 1'b1, 3'd0);
    @(negedge clk);
    cmp_out("in_rst", 4'b0000, 16'h0000, 1'b1, 3'd0);
    reset = 1'b1;
    tick();
    cmp_out("post_rst", 4'b0100, 16'hC0DE, 1'b0, 3'd2);

    // All four requesting: H cycles each in rotation.
    pulse_reset();
    req  = 4'b1111;
    data = 64'h4444_3333_2222_1111;
    for (int c = 0; c < 4 * N + 1; c++) begin
      tick();
      cmp($sformatf("rr%0d", c), 32'(grant),
          32'(4'(1) << ((c / H) % N)));
    end

    // Random traffic against the model.
    pulse_reset();
    req = '0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 299) begin
        pulse_reset();
      end
      if ($urandom_range(3) == 0) req = 4'($urandom);
      data = {$urandom, $urandom};
      model_step(req, data);
      tick();
      cmp("rnd.grant", 32'(grant),
          (m_own < 0) ? 32'd0 : 32'(4'(1) << m_own));
      cmp("rnd.val", 32'(disp_val), 32'(m_val));
      cmp("rnd.blank", 32'(disp_blank), (m_own < 0) ? 32'd1 : 32'd0);
      cmp("rnd.owner", 32'(owner_id), (m_own < 0) ? 32'd0 : 32'(m_own));
      cmp("rnd.onehot", 32'($countones(grant) <= 1), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
Shares the 4-digit seven-segment display between NUM_REQ independent requesters. Each requester presents a 16-bit hex value and a request line. A round-robin arbiter with a minimum hold time selects one owner and drives its value to the display driver's 16-bit input. It runs in the divided display clock domain and sits between the value producers and the display driver.

Parameters:
NUM_REQ, 4, number of requesters; legal values 2..8.
HOLD_CYCLES, 1000, minimum cycles an owner keeps the display while others wait; must be at least 1.
CNT_W, $clog2(HOLD_CYCLES+1), width of the hold counter; derived, not overridden.

Ports:
clk  input  1  single clock (divided display clock).
reset  input  1  reset, asynchronous and active-low.
req  input  NUM_REQ  per-requester request; level, held while display wanted.
data  input  16*NUM_REQ  flattened values; requester i uses bits [16*i+15:16*i].
grant  output  NUM_REQ  one-hot owner indication; all zero when idle.
disp_val  output  16  value to the display driver's input.
disp_blank  output  1  high when no owner; the display driver blanks all anodes.
owner_id  output  3  index of the current owner; 0 when idle.

Behaviour:
- Reset (reset=0, asynchronous): grant=0, disp_val=16'h0000, disp_blank=1, owner_id=0, state=IDLE, hold_cnt=0, rr_ptr=0. The block leaves reset on the first clk edge after reset returns high.
- State machine: IDLE and OWNED. All outputs are registered.
- Round-robin search: from start index s, the winner is the first i in s, s+1, ... wrapping mod NUM_REQ with req[i]=1.
- IDLE: if any req is high at edge k, then at edge k the block:
  - picks the winner w searching from rr_ptr;
  - sets grant=1<<w, owner_id=w, disp_val=data[w], disp_blank=0;
  - loads hold_cnt=HOLD_CYCLES-1 and goes to OWNED.
  - This is one-cycle latency from request to grant.
- IDLE with no req: all outputs hold their values, with disp_blank=1.
- OWNED, each edge, with o as the current owner:
  - disp_val<=data[o], so live value updates pass through with one cycle of latency.
  - hold_cnt decrements and saturates at 0.
- Owner drop: req[o]=0 in OWNED means immediate release, regardless of hold_cnt.
  - If another req is pending, grant passes directly to the winner searched from o+1, with no idle cycle between owners.
  - Otherwise the block returns to IDLE: grant=0, disp_blank=1, owner_id=0, and disp_val keeps its last value.
  - In both cases rr_ptr<=o+1 mod NUM_REQ.
- Hold expiry: hold_cnt=0 and req[o]=1 with any other req[j] (j≠o) high means preemption.
  - The winner is searched from o+1, so o is considered last and is never re-picked while another requester is pending.
  - hold_cnt reloads to HOLD_CYCLES-1 and rr_ptr<=o+1.
- Sole requester: hold_cnt=0 with only req[o] high means o keeps ownership indefinitely, and hold_cnt stays 0.
- Every new grant reloads hold_cnt=HOLD_CYCLES-1. With HOLD_CYCLES=1 the counter is always 0, so switching is possible every cycle.
- Simultaneous requests in IDLE: the lowest index at or after rr_ptr wins.
- Mid-operation reset: all outputs go to reset values immediately and asynchronously, and any pending ownership is lost.
- grant is always one-hot or zero, and disp_blank=1 exactly when grant=0.
- data inputs of non-owners are ignored. X on a non-owner's data must not propagate to disp_val.

Test Plan:
1. Reset then idle: reset low for 3 cycles, then high, with req=0 -> grant=0, disp_blank=1, disp_val=0000, owner_id=0 for 10 cycles.
2. Single request: req=0001, data0=16'h5555 at edge k -> after edge k: grant=0001, disp_val=5555, disp_blank=0. Change data0 to 1234 -> disp_val=1234 one cycle later.
3. Contention and hold: HOLD_CYCLES=4, req=0011 asserted together -> requester 0 owns for exactly 4 cycles, then requester 1 owns for 4, then 0 again. grant never shows 0000 or two bits.
4. Early drop: owner 2 drops req after 1 cycle while req3 is high -> grant=1000 on the next edge with no blank cycle. If no one else is requesting -> grant=0000 and disp_blank=1 on the next edge, while disp_val keeps the last value.
5. Round-robin fairness: all 4 req held high, HOLD_CYCLES=2 -> grant sequence 0001, 0010, 0100, 1000, 0001, with 2 cycles each.
6. Async reset mid-ownership: reset dropped between clock edges while grant=0100 -> grant=0, disp_blank=1, disp_val=0 before the next edge. After reset is released with req=0100 held -> grant returns one cycle later.
